// File: rtl/iob_eth_dma_pkg.sv
// Shared definitions for the Ethernet DMA schedulers: FSM states, status codes
// and TX-buffer geometry.
package iob_eth_dma_pkg;

    localparam int BUF_BYTES = 2048;
    localparam int BUF_IDX_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_CALC  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_DESC    = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/iob_eth_dma_r_sched_if.sv
// Descriptor and read-DMA handshake bundle; master = scheduler side,
// slave = CSR/descriptor source plus DMA engine side.
interface iob_eth_dma_r_sched_if
    import iob_eth_dma_pkg::*;
#(
    parameter int AXI_ADDR_W = 32
) ();

    logic                  desc_valid;
    logic                  desc_ready;
    logic [AXI_ADDR_W-1:0] desc_addr;
    logic [BUF_IDX_W-1:0]  desc_buf_start;
    logic [BUF_IDX_W-1:0]  desc_len;

    logic [AXI_ADDR_W-1:0] dma_addr;
    logic [BUF_IDX_W-1:0]  dma_start_index;
    logic [BUF_IDX_W-1:0]  dma_end_index;
    logic                  dma_run;
    logic                  dma_ready;

    modport master (
        input  desc_valid, desc_addr, desc_buf_start, desc_len, dma_ready,
        output desc_ready, dma_addr, dma_start_index, dma_end_index, dma_run
    );

    modport slave (
        output desc_valid, desc_addr, desc_buf_start, desc_len, dma_ready,
        input  desc_ready, dma_addr, dma_start_index, dma_end_index, dma_run
    );

endinterface

// File: rtl/iob_eth_dma_chunk_calc.sv
// Combinational chunk sizing: the largest piece of the remaining frame that
// stays inside one BOUNDARY-byte aligned memory window.
module iob_eth_dma_chunk_calc
    import iob_eth_dma_pkg::*;
#(
    parameter int BOUNDARY = 1024
) (
    input  logic [$clog2(BOUNDARY)-1:0] addr_off,
    input  logic [BUF_IDX_W-1:0]        remaining,
    output logic [BUF_IDX_W-1:0]        chunk
);

    // 13 bits hold any room value up to a 4096-byte window.
    logic [12:0] room;
    logic [12:0] rem_ext;

    assign room    = 13'(BOUNDARY) - 13'(addr_off);
    assign rem_ext = 13'(remaining);
    assign chunk   = BUF_IDX_W'((rem_ext <= room) ? rem_ext : room);

endmodule

// File: rtl/iob_eth_dma_r_sched.sv
// Ethernet TX read-DMA scheduler: splits one frame descriptor into
// boundary-safe chunks. Optional WAIT watchdog: IOB_ETH_DMA_R_SCHED_TIMEOUT_EN.
module iob_eth_dma_r_sched
    import iob_eth_dma_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int MAX_BEATS  = 256
`ifdef IOB_ETH_DMA_R_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 65535
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    iob_eth_dma_r_sched_if.master         bus,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    err,
    output logic [7:0]                    chunk_cnt
);

    localparam int BOUNDARY = 4 * MAX_BEATS;
    localparam int OFF_W    = $clog2(BOUNDARY);

    state_t                state_reg, state_next;
    logic [AXI_ADDR_W-1:0] addr_reg;
    logic [BUF_IDX_W-1:0]  buf_reg;
    logic [BUF_IDX_W-1:0]  rem_reg;
    logic [BUF_IDX_W-1:0]  chunk_reg;
    logic [BUF_IDX_W-1:0]  chunk_calc;
    logic                  abort_lat_reg;
    logic                  wait_first_reg;
    logic [1:0]            err_reg;
    logic [7:0]            chunk_cnt_reg;
    logic [AXI_ADDR_W-1:0] dma_addr_reg;
    logic [BUF_IDX_W-1:0]  dma_start_reg;
    logic [BUF_IDX_W-1:0]  dma_end_reg;

    logic desc_bad;
    logic wait_done;
    logic timeout_hit;
    logic abort_any;

    iob_eth_dma_chunk_calc #(
        .BOUNDARY (BOUNDARY)
    ) u_chunk_calc (
        .addr_off  (addr_reg[OFF_W-1:0]),
        .remaining (rem_reg),
        .chunk     (chunk_calc)
    );

    // 12-bit sum so a descriptor ending exactly at the buffer end is legal.
    assign desc_bad  = (rem_reg == '0) ||
                       (({1'b0, buf_reg} + {1'b0, rem_reg}) > 12'(BUF_BYTES));
    // The engine still shows ready in the cycle right after dma_run.
    assign wait_done = (state_reg == ST_WAIT) && !wait_first_reg && bus.dma_ready;
    assign abort_any = abort || abort_lat_reg;

`ifdef IOB_ETH_DMA_R_SCHED_TIMEOUT_EN
    logic [15:0] wait_cnt_reg;

    assign timeout_hit = (state_reg == ST_WAIT) && !wait_done &&
                         (wait_cnt_reg == 16'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (bus.desc_valid) state_next = ST_CHECK;
            ST_CHECK: state_next = desc_bad ? ST_DONE : ST_CALC;
            ST_CALC:  state_next = abort ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (bus.dma_ready) state_next = ST_WAIT;
            ST_WAIT: begin
                if (wait_done) begin
                    state_next = ST_NEXT;
                end else if (timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_NEXT: begin
                if (rem_reg == '0 || abort_any) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_CALC;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.desc_ready = 1'b0;
        bus.dma_run    = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                bus.desc_ready = 1'b1;
                busy           = 1'b0;
            end
            ST_ISSUE: bus.dma_run = bus.dma_ready;
            ST_DONE:  done        = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg       <= '0;
            buf_reg        <= '0;
            rem_reg        <= '0;
            chunk_reg      <= '0;
            abort_lat_reg  <= 1'b0;
            wait_first_reg <= 1'b0;
            err_reg        <= ERR_OK;
            chunk_cnt_reg  <= '0;
            dma_addr_reg   <= '0;
            dma_start_reg  <= '0;
            dma_end_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.desc_valid) begin
                        addr_reg      <= bus.desc_addr;
                        buf_reg       <= bus.desc_buf_start;
                        rem_reg       <= bus.desc_len;
                        chunk_cnt_reg <= '0;
                        err_reg       <= ERR_OK;
                        abort_lat_reg <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (desc_bad) err_reg <= ERR_DESC;
                end
                ST_CALC: begin
                    chunk_reg     <= chunk_calc;
                    dma_addr_reg  <= addr_reg;
                    dma_start_reg <= buf_reg;
                    dma_end_reg   <= buf_reg + chunk_calc - 11'd1;
                    if (abort) err_reg <= ERR_ABORT;
                end
                ST_ISSUE: begin
                    if (bus.dma_ready) begin
                        chunk_cnt_reg  <= sat_inc8(chunk_cnt_reg);
                        wait_first_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    wait_first_reg <= 1'b0;
                    if (abort) abort_lat_reg <= 1'b1;
                    if (wait_done) begin
                        addr_reg <= addr_reg + AXI_ADDR_W'(chunk_reg);
                        buf_reg  <= buf_reg + chunk_reg;
                        rem_reg  <= rem_reg - chunk_reg;
                    end else if (timeout_hit) begin
                        err_reg <= ERR_TIMEOUT;
                    end
                end
                ST_NEXT: begin
                    if (rem_reg != '0 && abort_any) err_reg <= ERR_ABORT;
                end
                default: ;
            endcase
        end
    end

    assign bus.dma_addr        = dma_addr_reg;
    assign bus.dma_start_index = dma_start_reg;
    assign bus.dma_end_index   = dma_end_reg;
    assign err                 = err_reg;
    assign chunk_cnt           = chunk_cnt_reg;

endmodule
